// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: streams 4-bit nibbles LSB first through
// a carry-lookahead slice and keeps the inter-nibble carry in a register.

module nibble_cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  // Carry into the slice MSB is needed by the parent for signed overflow.
  assign c3   = c[3];
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-5:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [3:0]       slice_sum;
  logic             slice_c3, slice_co;
  logic             last;

  nibble_cla4 u_slice (
    .x    (a_sh[3:0]),
    .y    (b_sh[3:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .c3   (slice_c3),
    .cout (slice_co)
  );

  assign last = (cnt == LAST);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : ci;
          cnt   <= '0;
        end
        RUN: begin
          // Result fills from the top; after NIB shifts the LSB nibble is at the bottom.
          r_sh  <= (WIDTH-4)'({slice_sum, r_sh} >> 4);
          carry <= slice_co;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          cnt   <= cnt + CW'(1);
          if (last) begin
            s   <= {slice_sum, r_sh};
            co  <= slice_co;
            ovf <= slice_c3 ^ slice_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16) plus a WIDTH=8 instance.

module tb_nibble_serial_adder;
  localparam int NIB = 4;

  logic        clk, rst;
  logic        start, sub, ci;
  logic [15:0] a, b;
  logic        busy, done, co, ovf;
  logic [15:0] s;

  logic        start8, sub8, ci8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ovf8;
  logic [7:0]  s8;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .ci(ci), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .ci(ci8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8)
  );

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    int          due;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_busy = 0;
  logic [15:0] exp_s;
  logic        exp_co, exp_ovf;
  logic [15:0] last_s;
  logic        last_co, last_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void ref_calc(input logic [15:0] x, input logic [15:0] y,
                                   input logic m, input logic c,
                                   output logic [15:0] rs, output logic rco, output logic rovf);
    logic [15:0] yv;
    logic [16:0] sum;
    yv   = m ? ~y : y;
    sum  = {1'b0, x} + {1'b0, yv} + {16'b0, (m ? 1'b1 : c)};
    rs   = sum[15:0];
    rco  = sum[16];
    rovf = (x[15] == yv[15]) && (rs[15] != x[15]);
  endfunction

  // Acceptance model: pushes the expectation attached to the inputs present at the accepting edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      sb.delete();
    end else begin
      cyc++;
      if (m_busy != 0) m_busy--;
      else if (start) begin
        sb.push_back('{s: exp_s, co: exp_co, ovf: exp_ovf, due: cyc + NIB});
        m_busy = NIB + 1;
      end
    end
  end

  // Monitor: compares status every cycle, results on done, and result hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_s   = '0;
      last_co  = 1'b0;
      last_ovf = 1'b0;
    end
    check("busy", {31'b0, busy}, {31'b0, m_busy != 0});
    check("done", {31'b0, done}, {31'b0, m_busy == 1});
    if (done) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("result_s",   {16'b0, s},   {16'b0, e.s});
        check("result_co",  {31'b0, co},  {31'b0, e.co});
        check("result_ovf", {31'b0, ovf}, {31'b0, e.ovf});
        check("latency",    cyc,          e.due);
        last_s   = e.s;
        last_co  = e.co;
        last_ovf = e.ovf;
      end
    end else begin
      check("hold_s",   {16'b0, s},   {16'b0, last_s});
      check("hold_co",  {31'b0, co},  {31'b0, last_co});
      check("hold_ovf", {31'b0, ovf}, {31'b0, last_ovf});
    end
  end

  task automatic run_op(input vec_t v);
    a = v.a; b = v.b; sub = v.sub; ci = v.ci;
    exp_s = v.s; exp_co = v.co; exp_ovf = v.ovf;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = ~sub; ci = ~ci;
    repeat (NIB + 2) @(posedge clk);
    #1;
  endtask

  vec_t vecs[7] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}
  };

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; a8 = '0; b8 = '0;
    exp_s = '0; exp_co = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_s",    {16'b0, s},    32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // start held high with fresh operands every cycle
    start = 1'b1;
    for (int i = 0; i < 26; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ci = 1'($urandom);
      ref_calc(a, b, sub, ci, exp_s, exp_co, exp_ovf);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (NIB + 2) @(posedge clk);
    #1;

    // reset two cycles into RUN: outputs clear at once, no done follows
    a = 16'hABCD; b = 16'h1111; sub = 1'b0; ci = 1'b0;
    exp_s = 16'hBCDE; exp_co = 1'b0; exp_ovf = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_s",    {16'b0, s},    32'h0);
    check("midrst_co",   {31'b0, co},   32'h0);
    check("midrst_ovf",  {31'b0, ovf},  32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    run_op(vecs[0]);

    // WIDTH=8 instance
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    n = 0;
    while (!done8 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", n, 2);
    check("w8_s",   {24'b0, s8},   32'h00);
    check("w8_co",  {31'b0, co8},  32'h1);
    check("w8_ovf", {31'b0, ovf8}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    n = 0;
    while ((sb.size() != 0 || m_busy != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder/subtractor that slices latched operands into 4-bit nibbles.
It feeds one nibble per clock, LSB first, through a combinational 4-bit carry-lookahead slice, and registers the inter-nibble carry between cycles.
It trades latency for area in wide datapaths where a full-width lookahead tree is too large.
It sits directly upstream of the 4-bit CLA slice, sequencing its operands and carry-in, and consumes the slice's sum and carry-out.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB (localparam), WIDTH/4, number of nibble iterations.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+ci, 1 = a-b (b inverted, carry-in forced to 1, ci ignored)
ci  input  1  carry-in for add mode
a  input  WIDTH  operand A, latched when start is accepted
b  input  WIDTH  operand B, latched when start is accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
s  output  WIDTH  result sum/difference
co  output  1  carry-out of bit WIDTH-1 (sub mode: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state -> IDLE; busy=0, done=0, s=0, co=0, ovf=0.
  - Operand shift registers, nibble counter and carry register are cleared.
  - The in-flight operation is discarded; no done pulse follows.
- States:
  - IDLE: start=1 at an edge -> RUN.
    - Latch a into the A shift register; latch b (or ~b when sub=1) into the B shift register.
    - Carry register <= (sub ? 1 : ci); counter <= 0.
  - RUN, each edge:
    - Slice computes a_sh[3:0] + b_sh[3:0] + carry.
    - The 4-bit sum is shifted into the MSB end of the result shift register.
    - Carry register <= slice carry-out; A/B registers shift right by 4; counter increments.
    - When counter == NIB-1 at the edge: transfer the full result to s; co <= slice carry-out.
    - Also at that edge: ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); the slice must expose its internal bit-3 carry for this.
    - Also at that edge: done <= 1; state -> DONE.
  - DONE: exactly one cycle; done=1 here only. Next edge -> IDLE, done <= 0.
- Latency: start accepted at edge k -> done high during the cycle following edge k+NIB. For WIDTH=16 that is 4 clocks.
- Throughput: one operation per NIB+2 cycles. Earliest next acceptance is the first edge in IDLE.
- start while busy=1 (RUN or DONE) is ignored, not queued. a/b/sub/ci changes during RUN do not affect the result.
- s/co/ovf hold their last values until the final RUN edge of the next operation. They are not cleared on start and never show partial results.
- Arithmetic is modulo 2^WIDTH. co is the true unsigned carry/not-borrow.

Test Plan:
- WIDTH=16, add, a=0x1234, b=0x4321, ci=0, start 1 cycle -> busy high 5 cycles; done pulses 1 cycle, 4 clocks after start edge; s=0x5555, co=0, ovf=0.
- add a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Then a=0x7FFF, b=0x0000, ci=1 -> s=0x8000, co=0, ovf=1. Carry ripples through all 4 nibble iterations.
- sub=1, a=0x0005, b=0x0007, ci=1 (ignored) -> s=0xFFFE, co=0, ovf=0. Then a=0x8000, b=0x0001 -> s=0x7FFF, co=1, ovf=1.
- start held high continuously with changing a/b -> accepted only in IDLE (every 6 cycles); each result matches the operands present at its acceptance edge; s holds old value until each done.
- assert rst 2 cycles into RUN -> s/co/ovf/busy/done immediately 0, no done pulse; a new start after reset release completes normally.
- WIDTH=8 instance, add a=0x80, b=0x80, ci=0 -> s=0x00, co=1, ovf=1; done 2 clocks after start edge.
